decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: DATA_W, 32, register/operand width (>=16).
REQ-002 Parameter: PC_W, 32, program-counter width.
REQ-003 Parameter: NREGS, 32, register-file depth (2..32); register index fields are always 5 bits.
REQ-004 clock  in  1  single clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  upstream handshake; in_pc in PC_W, in_instr in 32.
REQ-007 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-008 out_pc PC_W; out_rs_data, out_rt_data DATA_W; out_rd 5; out_boff 11 (instr[10:0]); out_imm 16 (instr[15:0]); out_simm DATA_W (instr[15:0] sign-extended); out_shamt 5 (instr[10:6]); out_ctrl 16 one-hot; out_illegal 1 -- all outputs, registered.
REQ-009 wb_en, wb_addr (5), wb_data (DATA_W)  in  write-back port.
REQ-010 resume  in  1  single-cycle pulse leaving HALTED; halted  out  1  state indicator.

Function
REQ-011 Fields: opcode instr[31:26], rs instr[25:21], rt instr[20:16], rd instr[15:11].
REQ-012 out_ctrl bit n set for opcode n, n = 0..14 (ADD, SUB, LI, SHL, SHR, AND, OR, XOR, BR, BNE, MOV, ADI, MUL, HLT, NOP); bit 15 always 0.
REQ-013 Opcode >= 15, or any of rs/rt/rd >= NREGS: out_ctrl = 0, out_illegal = 1; instruction writes nothing, otherwise passes normally.
REQ-014 Writers: opcodes 0-7 and 10-12; BR, BNE, HLT, NOP and illegal are non-writers.
REQ-015 Register 0 reads as zero; writes to address 0 or >= NREGS are ignored.
REQ-016 Output register loads when in_valid && in_ready; latency 1 cycle from acceptance to out_valid.
REQ-017 in_ready = RUN && !stall && (!out_valid || out_ready); full-throughput back-to-back when no stall.
REQ-018 out_valid clears on out_valid && out_ready with no new acceptance; outputs hold stable while out_valid && !out_ready.
REQ-019 Scoreboard: one pending bit per register; set for rd (rd != 0) when a writer is accepted; cleared when wb_en to that address; same-cycle set and clear of one address -> set wins.
REQ-020 stall = in_valid && (pending[rs] || pending[rt]) for the incoming instruction (register 0 never pending).
REQ-021 State machine RUN/HALTED: accepting HLT in RUN -> HALTED next cycle; HALTED -> RUN on resume; resume in RUN ignored; HLT itself is emitted downstream normally.
REQ-022 In HALTED: in_ready = 0, out_valid drains normally, write-back and scoreboard clears continue.
REQ-023 halted = 1 exactly while in HALTED.

Reset
REQ-024 reset_n low, immediately and regardless of clock: all registers, register file and scoreboard to 0, out_valid 0, all outputs 0, state RUN.
REQ-025 Reset mid-transfer discards the held instruction; no output beat survives.

Configuration
REQ-026 DECODE_WB_BYPASS_EN defined: operand read of an address being written this cycle returns wb_data, and the matching scoreboard clear releases the stall in that same cycle.
REQ-027 DECODE_WB_BYPASS_EN undefined: read returns the pre-write value and the stall releases one cycle after wb_en; write lands at the clock edge either way.

Structure
REQ-028 Shared package holds the opcode constants, the 16-bit control one-hot positions, the field bit positions and the RUN/HALTED state encoding.
REQ-029 One sub-module, decode_regfile: NREGS x DATA_W, two async read ports, one write port, optional bypass.

Verification
REQ-030 Reset, then write-back r1=0xFFFFFFFF, r2=0xAAAAAAAA; ADD rs=1 rt=2 rd=3, pc=0x40 -> next cycle out_valid, rs_data 0xFFFFFFFF, rt_data 0xAAAAAAAA, rd 3, out_ctrl 0x0001, pc 0x40.
REQ-031 ADI imm 0x8001 -> out_simm 0xFFFF8001, out_imm 0x8001, out_ctrl 0x0800; opcode 0x3F -> out_ctrl 0, out_illegal 1.
REQ-032 ADD rd=5 then SUB rs=5 -> SUB stalls (in_ready 0) until wb_en addr 5 with 0x1234; released same cycle (bypass) or next cycle (no bypass), rs_data 0x1234.
REQ-033 out_ready held 0 for 3 cycles with back-to-back input -> outputs stable, in_ready 0, no beat lost or duplicated.
REQ-034 HLT accepted -> halted 1, in_ready 0 with in_valid 1; resume pulse -> RUN next cycle, next instruction accepted.
REQ-035 reset_n asserted mid-stall with pending bits set -> out_valid 0, scoreboard clear, registers read 0.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Purpose  : Opcodes, control-vector layout, instruction field positions and
//            run/halt state encoding shared by the decode stage.
// Revision : 1.0
// ============================================================================
package decode_pkg;

  localparam int c_OPC_MSB   = 31;
  localparam int c_OPC_LSB   = 26;
  localparam int c_RS_MSB    = 25;
  localparam int c_RS_LSB    = 21;
  localparam int c_RT_MSB    = 20;
  localparam int c_RT_LSB    = 16;
  localparam int c_RD_MSB    = 15;
  localparam int c_RD_LSB    = 11;
  localparam int c_SHAMT_MSB = 10;
  localparam int c_SHAMT_LSB = 6;
  localparam int c_BOFF_MSB  = 10;
  localparam int c_IMM_MSB   = 15;

  // Control one-hot: bit n marks opcode n; the top bit is reserved and never set.
  localparam int c_CTRL_W    = 16;
  localparam int c_CTRL_RSVD = 15;

  typedef enum logic [5:0] {
    OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_LI  = 6'd2,  OP_SHL = 6'd3,
    OP_SHR = 6'd4,  OP_AND = 6'd5,  OP_OR  = 6'd6,  OP_XOR = 6'd7,
    OP_BR  = 6'd8,  OP_BNE = 6'd9,  OP_MOV = 6'd10, OP_ADI = 6'd11,
    OP_MUL = 6'd12, OP_HLT = 6'd13, OP_NOP = 6'd14
  } opcode_e;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  function automatic logic is_writer(input logic [5:0] opcode);
    return opcode inside {OP_ADD, OP_SUB, OP_LI, OP_SHL, OP_SHR, OP_AND,
                          OP_OR, OP_XOR, OP_MOV, OP_ADI, OP_MUL};
  endfunction

  function automatic logic reg_in_range(input logic [4:0] idx, input int nregs);
    return int'(idx) < nregs;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
// Module   : decode_regfile
// Purpose  : NREGS x DATA_W register file, two async reads, one write; r0 = 0.
//            DECODE_WB_BYPASS_EN forwards same-cycle write data to readers.
// Revision : 1.0
// ============================================================================
module decode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wr_ok;
  logic              w_hit_a, w_hit_b;
  logic              w_byp_a, w_byp_b;

  assign w_wr_ok = wr_en && (wr_addr != 5'd0) && reg_in_range(wr_addr, NREGS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign w_hit_a = (rd_addr_a != 5'd0) && reg_in_range(rd_addr_a, NREGS);
  assign w_hit_b = (rd_addr_b != 5'd0) && reg_in_range(rd_addr_b, NREGS);

`ifdef DECODE_WB_BYPASS_EN
  assign w_byp_a = w_wr_ok && (wr_addr == rd_addr_a);
  assign w_byp_b = w_wr_ok && (wr_addr == rd_addr_b);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign rd_data_a = !w_hit_a ? '0 : (w_byp_a ? wr_data : r_mem[rd_addr_a]);
  assign rd_data_b = !w_hit_b ? '0 : (w_byp_b ? wr_data : r_mem[rd_addr_b]);

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Instruction decode with register read, pending-write scoreboard,
//            run/halt control and a registered valid/ready output stage.
//            Option macro: DECODE_WB_BYPASS_EN (same-cycle write-back bypass).
// Revision : 1.0
// ============================================================================
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int NREGS  = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [31:0]         in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [DATA_W-1:0]   out_rs_data,
  output logic [DATA_W-1:0]   out_rt_data,
  output logic [4:0]          out_rd,
  output logic [10:0]         out_boff,
  output logic [15:0]         out_imm,
  output logic [DATA_W-1:0]   out_simm,
  output logic [4:0]          out_shamt,
  output logic [15:0]         out_ctrl,
  output logic                out_illegal,
  input  logic                wb_en,
  input  logic [4:0]          wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                resume,
  output logic                halted
);

  logic [5:0]          w_opcode;
  logic [4:0]          w_rs, w_rt, w_rd;
  logic [15:0]         w_imm;
  logic                w_illegal, w_writes, w_stall, w_in_ready, w_accept;
  logic [c_CTRL_W-1:0] w_ctrl;
  logic [31:0]         w_wb_clr, w_pend_set, w_pend_view, r_pending;
  logic [DATA_W-1:0]   w_rs_data, w_rt_data, w_simm;
  state_t              r_state, w_state_next;

  logic                r_out_valid, r_out_illegal;
  logic [PC_W-1:0]     r_out_pc;
  logic [DATA_W-1:0]   r_out_rs_data, r_out_rt_data, r_out_simm;
  logic [4:0]          r_out_rd, r_out_shamt;
  logic [10:0]         r_out_boff;
  logic [15:0]         r_out_imm, r_out_ctrl;

  assign w_opcode = in_instr[c_OPC_MSB:c_OPC_LSB];
  assign w_rs     = in_instr[c_RS_MSB:c_RS_LSB];
  assign w_rt     = in_instr[c_RT_MSB:c_RT_LSB];
  assign w_rd     = in_instr[c_RD_MSB:c_RD_LSB];
  assign w_imm    = in_instr[c_IMM_MSB:0];
  assign w_simm   = DATA_W'($signed(w_imm));

  assign w_illegal = (w_opcode > OP_NOP) || !reg_in_range(w_rs, NREGS) ||
                     !reg_in_range(w_rt, NREGS) || !reg_in_range(w_rd, NREGS);
  assign w_writes  = !w_illegal && is_writer(w_opcode) && (w_rd != 5'd0);

  always_comb begin
    w_ctrl = '0;
    if (!w_illegal) w_ctrl[w_opcode[3:0]] = 1'b1;
    w_ctrl[c_CTRL_RSVD] = 1'b0;
  end

  decode_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (w_rs),
    .rd_data_a (w_rs_data),
    .rd_addr_b (w_rt),
    .rd_data_b (w_rt_data)
  );

  assign w_wb_clr   = wb_en ? (32'd1 << wb_addr) : '0;
  assign w_pend_set = (w_accept && w_writes) ? (32'd1 << w_rd) : '0;

  // With bypass, a write-back landing this cycle already satisfies the hazard.
`ifdef DECODE_WB_BYPASS_EN
  assign w_pend_view = r_pending & ~w_wb_clr;
`else
  assign w_pend_view = r_pending;
`endif

  assign w_stall    = in_valid && (w_pend_view[w_rs] || w_pend_view[w_rt]);
  assign w_in_ready = (r_state == ST_RUN) && !w_stall && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_pending <= '0;
    else          r_pending <= (r_pending & ~w_wb_clr) | w_pend_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:    if (w_accept && !w_illegal && (w_opcode == OP_HLT)) w_state_next = ST_HALTED;
      ST_HALTED: if (resume) w_state_next = ST_RUN;
      default:   w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_rs_data <= '0;
      r_out_rt_data <= '0;
      r_out_rd      <= '0;
      r_out_boff    <= '0;
      r_out_imm     <= '0;
      r_out_simm    <= '0;
      r_out_shamt   <= '0;
      r_out_ctrl    <= '0;
      r_out_illegal <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_pc      <= in_pc;
      r_out_rs_data <= w_rs_data;
      r_out_rt_data <= w_rt_data;
      r_out_rd      <= w_rd;
      r_out_boff    <= in_instr[c_BOFF_MSB:0];
      r_out_imm     <= w_imm;
      r_out_simm    <= w_simm;
      r_out_shamt   <= in_instr[c_SHAMT_MSB:c_SHAMT_LSB];
      r_out_ctrl    <= w_ctrl;
      r_out_illegal <= w_illegal;
    end else if (r_out_valid && out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign halted      = (r_state == ST_HALTED);
  assign out_valid   = r_out_valid;
  assign out_pc      = r_out_pc;
  assign out_rs_data = r_out_rs_data;
  assign out_rt_data = r_out_rt_data;
  assign out_rd      = r_out_rd;
  assign out_boff    = r_out_boff;
  assign out_imm     = r_out_imm;
  assign out_simm    = r_out_simm;
  assign out_shamt   = r_out_shamt;
  assign out_ctrl    = r_out_ctrl;
  assign out_illegal = r_out_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the decode rules.
module tb_decode_stage;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int NREGS  = 32;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [31:0] in_instr;
  logic [DATA_W-1:0] out_rs_data, out_rt_data, out_simm, wb_data;
  logic [4:0] out_rd, out_shamt, wb_addr;
  logic [10:0] out_boff;
  logic [15:0] out_imm, out_ctrl;
  logic out_illegal, wb_en, resume, halted;

  always #5 clock = ~clock;

  decode_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_rd(out_rd),
    .out_boff(out_boff), .out_imm(out_imm), .out_simm(out_simm), .out_shamt(out_shamt),
    .out_ctrl(out_ctrl), .out_illegal(out_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .resume(resume), .halted(halted)
  );

  typedef struct {
    logic [31:0] pc, rs_data, rt_data, simm;
    logic [4:0]  rd, shamt;
    logic [10:0] boff;
    logic [15:0] imm, ctrl;
    logic        ill;
  } beat_t;

  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_halted, m_ov;
  beat_t       m_out;
  int          n_checks, n_pass;

  // ---------------- behavioural model ----------------
  function automatic int fld(input logic [31:0] w, input int lsb, input int width);
    logic [31:0] v;
    v = (w >> lsb) & ((32'd1 << width) - 32'd1);
    return int'(v);
  endfunction

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int rd, input int low);
    return 32'((op << 26) | (rs << 21) | (rt << 16) | (rd << 11) | low);
  endfunction

  function automatic bit m_illegal(input logic [31:0] w);
    return fld(w, 26, 6) >= 15 || fld(w, 21, 5) >= NREGS ||
           fld(w, 16, 5) >= NREGS || fld(w, 11, 5) >= NREGS;
  endfunction

  function automatic bit m_writer(input logic [31:0] w);
    return !m_illegal(w) && (fld(w, 26, 6) inside {[0:7], 10, 11, 12});
  endfunction

  function automatic logic [31:0] m_operand(input int a);
    if (a == 0) return 32'd0;
    if (BYPASS && wb_en && int'(wb_addr) == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_busy(input int a);
    return m_pend[a] && !(BYPASS && wb_en && int'(wb_addr) == a);
  endfunction

  function automatic bit m_ready();
    bit stall;
    stall = in_valid && (m_busy(fld(in_instr, 21, 5)) || m_busy(fld(in_instr, 16, 5)));
    return !m_halted && !stall && (!m_ov || out_ready);
  endfunction

  function automatic beat_t m_decode();
    beat_t b;
    int s, opc;
    opc       = fld(in_instr, 26, 6);
    b.pc      = in_pc;
    b.rs_data = m_operand(fld(in_instr, 21, 5));
    b.rt_data = m_operand(fld(in_instr, 16, 5));
    b.rd      = 5'(fld(in_instr, 11, 5));
    b.boff    = 11'(fld(in_instr, 0, 11));
    b.imm     = 16'(fld(in_instr, 0, 16));
    s         = fld(in_instr, 0, 16);
    if (s >= 32768) s = s - 65536;
    b.simm    = 32'(s);
    b.shamt   = 5'(fld(in_instr, 6, 5));
    b.ill     = m_illegal(in_instr);
    b.ctrl    = b.ill ? 16'd0 : 16'(1 << opc);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
    m_halted = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_clock();
    bit acc;
    beat_t nb;
    acc = in_valid && m_ready();
    nb  = m_decode();
    if (acc) begin m_out = nb; m_ov = 1'b1; end
    else if (m_ov && out_ready) m_ov = 1'b0;
    if (m_halted) begin
      if (resume) m_halted = 1'b0;
    end else if (acc && !nb.ill && fld(in_instr, 26, 6) == 13) m_halted = 1'b1;
    if (wb_en) m_pend[wb_addr] = 1'b0;
    if (acc && m_writer(in_instr) && nb.rd != 0) m_pend[nb.rd] = 1'b1;
    if (wb_en && wb_addr != 0 && int'(wb_addr) < NREGS) m_regs[wb_addr] = wb_data;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 0; in_pc = '0; in_instr = '0; out_ready = 1;
    wb_en = 0; wb_addr = '0; wb_data = '0; resume = 0;
  endtask

  task automatic drain_pending();
    in_valid = 0;
    for (int i = 1; i < 32; i++) begin
      if (m_pend[i]) begin wb_en = 1; wb_addr = 5'(i); wb_data = $urandom; tick(); end
    end
    wb_en = 0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 0; set_idle(); model_reset();
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_checks++; if ({out_pc, out_rs_data, out_rt_data, out_ctrl, out_illegal, out_rd} !== '0)
      $display("FAIL reset_outputs: got pc=%h rs=%h ctrl=%h ill=%b want all 0", out_pc, out_rs_data, out_ctrl, out_illegal); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    reset_n = 1;
    tick();
  endtask

  task automatic test_basic();
    wb_en = 1; wb_addr = 5'd1; wb_data = 32'hFFFF_FFFF; tick();
    wb_addr = 5'd2; wb_data = 32'hAAAA_AAAA; tick();
    wb_en = 0;
    in_valid = 1; in_pc = 32'h40; in_instr = mk(0, 1, 2, 3, 0);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL add_in_ready: got %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL add_out_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_rs_data !== 32'hFFFF_FFFF) $display("FAIL add_rs_data: got %h want ffffffff", out_rs_data); else n_pass++;
    n_checks++; if (out_rt_data !== 32'hAAAA_AAAA) $display("FAIL add_rt_data: got %h want aaaaaaaa", out_rt_data); else n_pass++;
    n_checks++; if ({out_rd, out_ctrl, out_pc} !== {5'd3, 16'h0001, 32'h40})
      $display("FAIL add_rd_ctrl_pc: got rd=%0d ctrl=%h pc=%h want rd=3 ctrl=0001 pc=40", out_rd, out_ctrl, out_pc); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL add_drain: got out_valid %b want 0", out_valid); else n_pass++;
    drain_pending();
  endtask

  task automatic test_imm();
    in_valid = 1; in_pc = 32'h44; in_instr = mk(11, 0, 0, 0, 0) | 32'h8001;
    tick();
    n_checks++; if (out_simm !== 32'hFFFF_8001) $display("FAIL adi_simm: got %h want ffff8001", out_simm); else n_pass++;
    n_checks++; if ({out_imm, out_ctrl, out_illegal} !== {16'h8001, 16'h0800, 1'b0})
      $display("FAIL adi_imm_ctrl: got imm=%h ctrl=%h ill=%b want 8001 0800 0", out_imm, out_ctrl, out_illegal); else n_pass++;
    in_pc = 32'h48; in_instr = 32'hFC00_0000;
    tick();
    in_valid = 0;
    n_checks++; if ({out_ctrl, out_illegal} !== {16'h0000, 1'b1})
      $display("FAIL illegal_op: got ctrl=%h ill=%b want 0000 1", out_ctrl, out_illegal); else n_pass++;
    drain_pending();
  endtask

  task automatic test_stall();
    int lat;
    in_valid = 1; in_pc = 32'h50; in_instr = mk(0, 0, 0, 5, 0);
    tick();
    in_pc = 32'h54; in_instr = mk(1, 5, 0, 6, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_hold cyc %0d: got in_ready %b want 0", c, in_ready); else n_pass++;
      tick();
    end
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'h1234;
    lat = -1;
    for (int c = 0; c < 4 && lat < 0; c++) begin
      #1;
      if (in_ready) lat = c;
      tick();
      wb_en = 0;
    end
    in_valid = 0;
    n_checks++; if (lat != (BYPASS ? 0 : 1)) $display("FAIL stall_release: got latency %0d want %0d", lat, BYPASS ? 0 : 1); else n_pass++;
    n_checks++; if ({out_valid, out_pc, out_rs_data} !== {1'b1, 32'h54, 32'h1234})
      $display("FAIL stall_sub_beat: got v=%b pc=%h rs=%h want 1 54 1234", out_valid, out_pc, out_rs_data); else n_pass++;
    drain_pending();
  endtask

  task automatic test_backpressure();
    logic [31:0] got [$];
    logic [31:0] sent [$];
    logic [31:0] pc;
    pc = 32'h100;
    in_valid = 1; in_pc = pc; in_instr = mk(14, 0, 0, 0, $urandom_range(0, 2047));
    tick(); sent.push_back(pc); pc += 4;
    in_pc = pc; in_instr = mk(14, 0, 0, 0, $urandom_range(0, 2047));
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d: got %b want 0", c, in_ready); else n_pass++;
      n_checks++; if ({out_valid, out_pc} !== {1'b1, 32'h100})
        $display("FAIL bp_stable cyc %0d: got v=%b pc=%h want 1 100", c, out_valid, out_pc); else n_pass++;
      tick();
    end
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_resume cyc %0d: got in_ready %b want 1", c, in_ready); else n_pass++;
      if (out_valid) got.push_back(out_pc);
      tick(); sent.push_back(pc); pc += 4;
      in_pc = pc; in_instr = mk(14, 0, 0, 0, $urandom_range(0, 2047));
    end
    in_valid = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid) got.push_back(out_pc);
      tick();
    end
    n_checks++; if (got.size() != sent.size()) $display("FAIL bp_count: got %0d beats want %0d", got.size(), sent.size()); else n_pass++;
    for (int i = 0; i < sent.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== sent[i]) $display("FAIL bp_order beat %0d: got pc %h want %h", i, got[i], sent[i]); else n_pass++;
    end
  endtask

  task automatic test_halt();
    in_valid = 1; in_pc = 32'h200; in_instr = mk(13, 0, 0, 0, 0);
    tick();
    n_checks++; if ({halted, out_valid, out_ctrl} !== {1'b1, 1'b1, 16'h2000})
      $display("FAIL hlt_emit: got halted=%b v=%b ctrl=%h want 1 1 2000", halted, out_valid, out_ctrl); else n_pass++;
    in_pc = 32'h204; in_instr = mk(14, 0, 0, 0, 0);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL hlt_block: got in_ready %b want 0", in_ready); else n_pass++;
    tick();
    n_checks++; if ({halted, out_valid} !== 2'b10) $display("FAIL hlt_drain: got halted=%b v=%b want 1 0", halted, out_valid); else n_pass++;
    resume = 1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL hlt_resume_cycle: got in_ready %b want 0", in_ready); else n_pass++;
    tick();
    resume = 0;
    #1;
    n_checks++; if ({halted, in_ready} !== 2'b01) $display("FAIL hlt_run: got halted=%b ready=%b want 0 1", halted, in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_checks++; if ({out_valid, out_pc} !== {1'b1, 32'h204}) $display("FAIL hlt_next: got v=%b pc=%h want 1 204", out_valid, out_pc); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    wb_en = 1; wb_addr = 5'd4; wb_data = 32'hDEAD_BEEF; tick();
    wb_en = 0;
    in_valid = 1; in_pc = 32'h2FC; in_instr = mk(0, 0, 0, 7, 0);
    tick();
    out_ready = 0;
    in_pc = 32'h300; in_instr = mk(1, 7, 4, 8, 0);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rmid_stall: got in_ready %b want 0", in_ready); else n_pass++;
    tick();
    #2;
    reset_n = 0;
    #1;
    model_reset();
    n_checks++; if ({out_valid, out_pc, out_ctrl} !== '0)
      $display("FAIL rmid_async: got v=%b pc=%h ctrl=%h want 0 0 0", out_valid, out_pc, out_ctrl); else n_pass++;
    @(posedge clock);
    #1;
    reset_n = 1; out_ready = 1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rmid_sb_clear: got in_ready %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_checks++; if ({out_valid, out_pc, out_rs_data, out_rt_data} !== {1'b1, 32'h300, 32'h0, 32'h0})
      $display("FAIL rmid_regs: got v=%b pc=%h rs=%h rt=%h want 1 300 0 0", out_valid, out_pc, out_rs_data, out_rt_data); else n_pass++;
    drain_pending();
  endtask

  task automatic test_random();
    int p, op;
    for (int cyc = 0; cyc < 400; cyc++) begin
      p  = $urandom_range(0, 19);
      op = (p < 15) ? p : ((p < 18) ? $urandom_range(0, 12) : 63);
      if (op == 13 && $urandom_range(0, 3) != 0) op = 14;
      in_valid  = ($urandom_range(0, 99) < 70);
      in_pc     = $urandom;
      in_instr  = mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2047));
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_addr   = 5'($urandom_range(0, 9));
      wb_data   = $urandom;
      resume    = m_halted ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      #1;
      n_checks++; if (in_ready !== m_ready()) $display("FAIL rand_in_ready cyc %0d: got %b want %b", cyc, in_ready, m_ready()); else n_pass++;
      tick();
      n_checks++; if ({out_valid, halted} !== {m_ov, m_halted})
        $display("FAIL rand_state cyc %0d: got v=%b halted=%b want v=%b halted=%b", cyc, out_valid, halted, m_ov, m_halted); else n_pass++;
      if (m_ov) begin
        n_checks++;
        if ({out_pc, out_rs_data, out_rt_data, out_rd, out_boff, out_imm, out_simm, out_shamt, out_ctrl, out_illegal} !==
            {m_out.pc, m_out.rs_data, m_out.rt_data, m_out.rd, m_out.boff, m_out.imm, m_out.simm, m_out.shamt, m_out.ctrl, m_out.ill})
          $display("FAIL rand_beat cyc %0d: got pc=%h rs=%h rt=%h rd=%h boff=%h imm=%h simm=%h sh=%h ctrl=%h ill=%b want pc=%h rs=%h rt=%h rd=%h boff=%h imm=%h simm=%h sh=%h ctrl=%h ill=%b",
                   cyc, out_pc, out_rs_data, out_rt_data, out_rd, out_boff, out_imm, out_simm, out_shamt, out_ctrl, out_illegal,
                   m_out.pc, m_out.rs_data, m_out.rt_data, m_out.rd, m_out.boff, m_out.imm, m_out.simm, m_out.shamt, m_out.ctrl, m_out.ill);
        else n_pass++;
      end
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0;
    test_reset();
    test_basic();
    test_imm();
    test_stall();
    test_backpressure();
    test_halt();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
